// File: rtl/cpu_ram_burst_swiz_pkg.sv
// Shared types and the per-lane row helper for the lane-interleaved CPU RAM swizzler.
// Used by cpu_ram_burst_swiz, cpu_ram_lane_row and cpu_ram_burst_swiz_if.
package lu_new;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  localparam int LU_SWIZ_BITS = 2;
  localparam int LU_NUM_LANES = 2 ** LU_SWIZ_BITS;

  typedef logic [LU_NUM_LANES-1:0] lane_mask_t;

  // Row of the word living in `lane` within the window starting at `addr`.
  // Lanes below the burst's starting lane hold the word one row further on.
  function automatic logic [31:0] swiz_row(input logic [31:0] addr, input int lane,
                                           input logic [31:0] low, input int swiz_bits);
    logic [31:0] r;
    r = addr >> swiz_bits;
    if (lane < int'(low)) r = r + 32'd1;
    return r;
  endfunction

endpackage

// File: rtl/cpu_ram_burst_swiz_if.sv
// Request/beat bus of cpu_ram_burst_swiz; o_word_lane exists only when
// CPU_RAM_BURST_SWIZ_ROTATE_EN is defined.
interface cpu_ram_burst_swiz_if #(
    parameter int ADDR_BITS = 16,
    parameter int SWIZ_BITS = 2,
    parameter int LEN_BITS  = 8
);
    localparam int NUM_LANES = 2 ** SWIZ_BITS;
    localparam int ROW_BITS  = ADDR_BITS - SWIZ_BITS;

    // Handshakes: a request transfers on a rising edge where i_valid && o_ready, a beat
    // on a rising edge where o_valid && i_ready; a stalled beat holds every output stable.
    logic                                 i_valid;
    logic                                 o_ready;
    logic [ADDR_BITS-1:0]                 i_addr;
    logic [LEN_BITS-1:0]                  i_len;
    logic                                 o_valid;
    logic                                 i_ready;
    logic [NUM_LANES-1:0][ROW_BITS-1:0]   o_row;
    logic [NUM_LANES-1:0]                 o_lane_en;
    logic [SWIZ_BITS-1:0]                 o_first_lane;
    logic                                 o_last;
    lu_new::state_t                       dbg_state;
`ifdef CPU_RAM_BURST_SWIZ_ROTATE_EN
    logic [NUM_LANES-1:0][SWIZ_BITS-1:0]  o_word_lane;
`endif

    modport slave (
        input  i_valid, i_addr, i_len, i_ready,
        output o_ready, o_valid, o_row, o_lane_en, o_first_lane, o_last, dbg_state
`ifdef CPU_RAM_BURST_SWIZ_ROTATE_EN
        , output o_word_lane
`endif
    );

    modport master (
        output i_valid, i_addr, i_len, i_ready,
        input  o_ready, o_valid, o_row, o_lane_en, o_first_lane, o_last, dbg_state
`ifdef CPU_RAM_BURST_SWIZ_ROTATE_EN
        , input o_word_lane
`endif
    );

endinterface

// File: rtl/cpu_ram_burst_swiz_lane_row.sv
// cpu_ram_lane_row: combinational row address and enable for one RAM lane,
// given the beat start address, the burst's starting lane and the words remaining.
module cpu_ram_lane_row
    import lu_new::*;
#(
    parameter int ADDR_BITS = 16,
    parameter int SWIZ_BITS = 2,
    parameter int LEN_BITS  = 8,
    parameter int LANE      = 0,
    localparam int ROW_BITS = ADDR_BITS - SWIZ_BITS
) (
    input  logic [ADDR_BITS-1:0] s,
    input  logic [SWIZ_BITS-1:0] low,
    input  logic [LEN_BITS-1:0]  rem,
    output logic [ROW_BITS-1:0]  row,
    output logic                 en
);
    localparam logic [SWIZ_BITS-1:0] LANE_IDX = SWIZ_BITS'(LANE);

    logic [SWIZ_BITS-1:0] off;

    // off is always below NUM_LANES, so comparing with rem alone equals min(rem, NUM_LANES).
    always_comb begin
        row = ROW_BITS'(swiz_row(32'(s), LANE, 32'(low), SWIZ_BITS));
        off = LANE_IDX - low;
        en  = 32'(off) < 32'(rem);
    end

endmodule

// File: rtl/cpu_ram_burst_swiz.sv
// Burst address swizzler: turns (base, length) requests into one registered beat per
// cycle of per-lane rows and lane enables. Optional CPU_RAM_BURST_SWIZ_ROTATE_EN adds o_word_lane.
module cpu_ram_burst_swiz
    import lu_new::*;
#(
    parameter int ADDR_BITS = 16,
    parameter int SWIZ_BITS = 2,
    parameter int LEN_BITS  = 8
) (
    input  logic            clk,
    input  logic            reset,
    cpu_ram_burst_swiz_if.slave bus
);
    localparam int NUM_LANES = 2 ** SWIZ_BITS;
    localparam int ROW_BITS  = ADDR_BITS - SWIZ_BITS;
    localparam logic [LEN_BITS-1:0]  LANES_LEN  = LEN_BITS'(NUM_LANES);
    localparam logic [ADDR_BITS-1:0] LANES_ADDR = ADDR_BITS'(NUM_LANES);

    state_t                             state;
    logic                               ready_q;
    logic                               valid_q;
    logic                               last_q;
    logic [SWIZ_BITS-1:0]               first_q;
    logic [NUM_LANES-1:0][ROW_BITS-1:0] row_q;
    logic [NUM_LANES-1:0]               en_q;
    logic [ADDR_BITS-1:0]               s_q;
    logic [LEN_BITS-1:0]                rem_q;

    logic                               start;
    logic                               step;
    logic                               load;
    logic [ADDR_BITS-1:0]               nxt_s;
    logic [SWIZ_BITS-1:0]               nxt_low;
    logic [LEN_BITS-1:0]                nxt_rem;
    logic [ROW_BITS-1:0]                row_w [NUM_LANES];
    logic                               en_w  [NUM_LANES];

    // first_q doubles as the latched starting lane: it is constant for the whole burst.
    always_comb begin
        start   = (state == ST_IDLE) && ready_q && bus.i_valid && (bus.i_len != '0);
        step    = (state == ST_BURST) && bus.i_ready && !last_q;
        load    = start || step;
        nxt_s   = start ? bus.i_addr : s_q + LANES_ADDR;
        nxt_low = start ? bus.i_addr[SWIZ_BITS-1:0] : first_q;
        nxt_rem = start ? bus.i_len : rem_q - LANES_LEN;
    end

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        cpu_ram_lane_row #(
            .ADDR_BITS (ADDR_BITS),
            .SWIZ_BITS (SWIZ_BITS),
            .LEN_BITS  (LEN_BITS),
            .LANE      (l)
        ) u_lane_row (
            .s   (nxt_s),
            .low (nxt_low),
            .rem (nxt_rem),
            .row (row_w[l]),
            .en  (en_w[l])
        );
    end

`ifdef CPU_RAM_BURST_SWIZ_ROTATE_EN
    logic [NUM_LANES-1:0][SWIZ_BITS-1:0] wl_q;
    logic [SWIZ_BITS-1:0]                wl_w [NUM_LANES];

    // Slot j carries the word (low + j); slots past the words remaining read 0.
    for (genvar j = 0; j < NUM_LANES; j++) begin : g_slot
        assign wl_w[j] = (32'(j) < 32'(nxt_rem)) ? nxt_low + SWIZ_BITS'(j) : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wl_q <= '0;
        end else if (load) begin
            for (int j = 0; j < NUM_LANES; j++) wl_q[j] <= wl_w[j];
        end
    end

    assign bus.o_word_lane = wl_q;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            first_q <= '0;
            row_q   <= '0;
            en_q    <= '0;
            s_q     <= '0;
            rem_q   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    ready_q <= 1'b1;
                    if (start) begin
                        state   <= ST_BURST;
                        ready_q <= 1'b0;
                        valid_q <= 1'b1;
                    end
                end
                ST_BURST: begin
                    if (bus.i_ready && last_q) begin
                        state   <= ST_IDLE;
                        ready_q <= 1'b1;
                        valid_q <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (load) begin
                s_q     <= nxt_s;
                rem_q   <= nxt_rem;
                first_q <= nxt_low;
                last_q  <= (nxt_rem <= LANES_LEN);
                for (int l = 0; l < NUM_LANES; l++) begin
                    row_q[l] <= row_w[l];
                    en_q[l]  <= en_w[l];
                end
            end
        end
    end

    assign bus.o_ready      = ready_q;
    assign bus.o_valid      = valid_q;
    assign bus.o_row        = row_q;
    assign bus.o_lane_en    = en_q;
    assign bus.o_first_lane = first_q;
    assign bus.o_last       = last_q;
    assign bus.dbg_state    = state;

endmodule

// File: tb/tb_cpu_ram_burst_swiz.sv
// Self-checking bench for cpu_ram_burst_swiz: directed scenarios plus random bursts,
// beats compared against a word-level reference model through an expected queue.
`timescale 1ns/1ps
module tb_cpu_ram_burst_swiz;
  import lu_new::*;

  localparam int AB = 16;
  localparam int SB = 2;
  localparam int LB = 8;
  localparam int NL = 4;
  localparam int RB = AB - SB;
  localparam int OW = 1 + NL*RB + NL + SB + 1 + NL*SB;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  cpu_ram_burst_swiz_if #(.ADDR_BITS(AB), .SWIZ_BITS(SB), .LEN_BITS(LB)) bus();

  cpu_ram_burst_swiz #(.ADDR_BITS(AB), .SWIZ_BITS(SB), .LEN_BITS(LB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int beats_seen = 0;
  logic rand_ready = 1'b0;
  logic [OW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [OW-1:0] pack_obs();
    logic [NL*SB-1:0] wl;
    wl = '0;
`ifdef CPU_RAM_BURST_SWIZ_ROTATE_EN
    wl = bus.o_word_lane;
`endif
    return {bus.o_valid, bus.o_row, bus.o_lane_en, bus.o_first_lane, bus.o_last, wl};
  endfunction

  // Reference: beat k covers burst words k*NL .. k*NL+NL-1; lane l holds the word at
  // offset (l - low) mod NL within that window.
  function automatic logic [OW-1:0] model_beat(input int addr, input int len, input int k);
    logic [NL-1:0][RB-1:0] rows;
    lane_mask_t            en;
    logic [NL-1:0][SB-1:0] wl;
    int low, base, off, a;
    low  = addr % NL;
    base = k * NL;
    for (int l = 0; l < NL; l++) begin
      off     = (l - low + NL) % NL;
      a       = (addr + base + off) % (1 << AB);
      rows[l] = RB'(a / NL);
      en[l]   = (base + off) < len;
    end
    for (int j = 0; j < NL; j++)
      wl[j] = (base + j < len) ? SB'((addr + base + j) % NL) : SB'(0);
`ifndef CPU_RAM_BURST_SWIZ_ROTATE_EN
    wl = '0;
`endif
    return {1'b1, rows, en, SB'(low), (base + NL >= len), wl};
  endfunction

  task automatic push_burst(input int addr, input int len);
    for (int k = 0; k < (len + NL - 1) / NL; k++) exp_q.push_back(model_beat(addr, len, k));
  endtask

  // driver tasks
  task automatic send(input int addr, input int len);
    int t;
    t = 0;
    @(negedge clk);
    while (!bus.o_ready && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check("ready_wait", OW'(t < 1000), OW'(1));
    push_burst(addr, len);
    bus.i_valid = 1'b1;
    bus.i_addr  = AB'(addr);
    bus.i_len   = LB'(len);
    @(posedge clk);
    #1 bus.i_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || !bus.o_ready) && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check("drain", OW'(exp_q.size() == 0 && bus.o_ready), OW'(1));
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_ready) bus.i_ready = 1'($urandom_range(0, 1));
  end

  // scoreboard
  logic [OW-1:0] prev_obs = '0;
  logic          prev_stall = 1'b0;
  always @(negedge clk) begin
    logic [OW-1:0] obs;
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      obs = pack_obs();
      if (prev_stall) check("hold", obs, prev_obs);
      if (bus.o_valid && bus.i_ready) begin
        beats_seen++;
        if (exp_q.size() == 0) check("extra_beat", obs, '0);
        else check("beat", obs, exp_q.pop_front());
      end
      prev_stall = bus.o_valid && !bus.i_ready;
      prev_obs   = obs;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, t, addr, len;
    bus.i_valid = 1'b0;
    bus.i_addr  = '0;
    bus.i_len   = '0;
    bus.i_ready = 1'b1;

    repeat (2) @(negedge clk);
    check("rst_ready", OW'(bus.o_ready), OW'(0));
    check("rst_outputs", pack_obs(), '0);
    check("rst_state", OW'(bus.dbg_state), OW'(ST_IDLE));
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("post_rst_ready", OW'(bus.o_ready), OW'(1));
    check("post_rst_valid", OW'(bus.o_valid), OW'(0));

    // misaligned burst
    send(6, 5);
    drain();

    // backpressure on beat0 for three cycles
    bus.i_ready = 1'b0;
    b0 = beats_seen;
    send(6, 5);
    repeat (3) @(posedge clk);
    check("bp_no_handshake", OW'(beats_seen), OW'(b0));
    check("bp_valid", OW'(bus.o_valid), OW'(1));
    #1 bus.i_ready = 1'b1;
    drain();
    check("bp_beats", OW'(beats_seen), OW'(b0 + 2));

    // zero length, then a normal request
    send(16'h0010, 0);
    @(negedge clk);
    check("zl_ready", OW'(bus.o_ready), OW'(1));
    for (int i = 0; i < 4; i++) begin
      check("zl_valid", OW'(bus.o_valid), OW'(0));
      @(negedge clk);
    end
    send(16'h0021, 3);
    drain();

    // wrap past top of memory
    send(16'hFFFE, 4);
    drain();

    // reset mid-burst after beat1
    b0 = beats_seen;
    send(0, 16);
    t = 0;
    while (beats_seen < b0 + 2 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("mid_beats", OW'(beats_seen), OW'(b0 + 2));
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("mid_rst_valid", OW'(bus.o_valid), OW'(0));
    check("mid_rst_ready", OW'(bus.o_ready), OW'(0));
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid_post_ready", OW'(bus.o_ready), OW'(1));
    check("mid_post_valid", OW'(bus.o_valid), OW'(0));
    send(4, 4);
    drain();

    // rotate slots (word lanes compare as 0 when the option is absent)
    send(3, 4);
    drain();
    send(3, 2);
    drain();

    // random bursts with random backpressure
    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      addr = int'($urandom_range(0, 65535));
      len  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 12));
      if (i % 10 == 0) addr = 65536 - int'($urandom_range(1, 8));
      send(addr, len);
    end
    drain();
    rand_ready = 1'b0;
    bus.i_ready = 1'b1;

    check("queue_empty", OW'(exp_q.size()), OW'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cpu_ram_burst_swiz.md
# cpu_ram_burst_swiz

Multi-lane burst address swizzler for the lane-interleaved CPU-side RAM in the LU design. It accepts a (base address, word count) request on a valid/ready handshake and emits one beat per cycle. Each beat carries the per-lane RAM row address and lane-enable mask for up to `NUM_LANES` consecutive words. It replaces per-lane single-address swizzling with one block that serves all lanes and whole bursts.

## Interface

Parameters:
- `ADDR_BITS`, 16: flat word-address width.
- `SWIZ_BITS`, 2: lane-select bits. `NUM_LANES = 2**SWIZ_BITS`. `ROW_BITS = ADDR_BITS - SWIZ_BITS`.
- `LEN_BITS`, 8: burst length field width, in words.

Ports:
- `clk`, input, 1: sole clock. All logic on rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `i_valid`, input, 1: request valid.
- `o_ready`, output, 1: request accepted when `i_valid && o_ready`.
- `i_addr`, input, `ADDR_BITS`: first word address.
- `i_len`, input, `LEN_BITS`: number of words. 0 is legal.
- `o_valid`, output, 1: beat valid.
- `i_ready`, input, 1: downstream accepts the beat.
- `o_row`, output, `NUM_LANES` x `ROW_BITS`: row address for each lane.
- `o_lane_en`, output, `NUM_LANES`: lane participates in this beat.
- `o_first_lane`, output, `SWIZ_BITS`: lane holding the lowest-address word of the beat.
- `o_last`, output, 1: final beat of the burst.

## Operation

- Word mapping: address `a` lives in lane `a[SWIZ_BITS-1:0]`, row `a[ADDR_BITS-1:SWIZ_BITS]`.
- Definitions:
  - `low = i_addr[SWIZ_BITS-1:0]`, latched at accept. It is constant for the whole burst.
  - Beat `k` starts at `s = i_addr + k*NUM_LANES`.
- Per-lane row: `o_row[l] = s[ADDR_BITS-1:SWIZ_BITS] + (l < low ? 1 : 0)`. Arithmetic is modulo `2**ROW_BITS`, so the row silently wraps past the top of memory.
- Lane enable:
  - `o_lane_en[l] = ((l - low) mod NUM_LANES) < min(rem, NUM_LANES)`.
  - `rem` is the number of words still to be issued, including this beat.
- Beats per burst: `ceil(i_len / NUM_LANES)`. `o_last` is high on the beat where `rem <= NUM_LANES`.
- FSM states:
  - IDLE: `o_ready=1`, `o_valid=0`.
    - Accept with `i_len != 0`: latch the request and go to BURST.
    - Accept with `i_len == 0`: consumed, no beat issued, stay in IDLE.
  - BURST: `o_ready=0`, `o_valid=1`.
    - On `i_ready`: advance `s` by `NUM_LANES` and decrement `rem` by `min(rem, NUM_LANES)`.
    - If the handshaken beat had `o_last`, go to IDLE.
- Backpressure: while `o_valid && !i_ready`, every output holds stable.
- Reset values:
  - `o_valid=0`, `o_ready=0` while `reset` is high, then 1 from the first cycle after release.
  - `o_row=0`, `o_lane_en=0`, `o_first_lane=0`, `o_last=0`.
  - FSM in IDLE.
- Reset mid-burst aborts the burst immediately. No partial beat follows release.

## Timing

- All outputs are registered.
- Request accepted at edge t → first beat valid from t+1.
- Throughput: one beat per cycle under continuous `i_ready`.
- Bubble: at least one IDLE cycle between bursts, because `o_ready` is only high in IDLE.
- `o_ready` does not depend combinationally on `i_valid` or `i_ready`.

## Configuration

- `CPU_RAM_BURST_SWIZ_ROTATE_EN` defined: adds output `o_word_lane`, `NUM_LANES` x `SWIZ_BITS`, registered with the beat.
  - `o_word_lane[j] = (low + j) mod NUM_LANES`: the lane supplying word slot `j`, for downstream data crossbar control.
  - Slots beyond `min(rem, NUM_LANES)` read 0.
  - Reset value 0.
- Not defined: the port and its logic are absent. All other behaviour is identical.

## Structure

- Package `lu_new` gains:
  - Function `swiz_row(addr, lane)`, implementing the per-lane row formula.
  - Typedef for the lane-enable mask.
- Sub-module `cpu_ram_lane_row`: combinational, one instance per lane via generate. Computes `o_row[l]` and `o_lane_en[l]` from `s`, `low` and `rem`.
- The FSM, counters and output registers live in the top module.

## Test plan

All scenarios use `ADDR_BITS=16`, `SWIZ_BITS=2`, `LEN_BITS=8`.

1. Misaligned burst: `addr=0x0006`, `len=5`.
   - Beat0: `o_row={2,2,1,1}` for lanes 0..3, `en=4'b1111`, `first_lane=2`, `last=0`.
   - Beat1: `o_row={3,3,2,2}`, `en=4'b0100`, `last=1`.
2. Backpressure: same request with `i_ready` low for 3 cycles on beat0 → outputs constant for all 3 cycles, beat1 only after the handshake, no beat lost or repeated.
3. Zero length: `len=0` → `o_valid` never rises. `o_ready` high the cycle after accept. The next request is served normally.
4. Wrap-around: `addr=0xFFFE`, `len=4` → single beat, lanes 2,3 row `0x3FFF`, lanes 0,1 row `0x0000`, `en=4'b1111`, `last=1`.
5. Reset mid-burst: `addr=0`, `len=16`, `reset` asserted after beat1 handshake → `o_valid` low asynchronously. `o_ready` high after release. A new request `addr=4`, `len=4` yields one beat with `o_row=1` in all lanes.
6. Rotate enabled: `addr=0x0003`, `len=4` → `o_word_lane={3,0,1,2}` for slots 0..3. With `len=2`: `{3,0,0,0}`.
